// File: rtl/prio_arb_sel.sv
// Registered N-way priority selector, fixed-priority or round-robin chosen at runtime.
// Latency: 1 cycle from req to out_valid; gnt is combinational in the capture cycle.
// Backpressure: out_valid && !out_ready stalls; gnt stays 0 and held output is stable.
module prio_arb_sel #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   gnt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_idx
);

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] r_ptr;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic          w_cap;
    logic [W-1:0]  w_data;
    logic [IW-1:0] w_ptr_nxt;

    // Winner search: start at 0 (fixed) or at the rotating pointer (round-robin), wrapping at N.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N; k++) begin
            j = (mode ? int'(r_ptr) : 0) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                w_win   = IW'(j);
            end
        end
    end

    // Capture when someone requests and the output slot is free or being drained;
    // gated by rst_n so no grant escapes while the block is held in reset.
    assign w_cap     = rst_n && w_found && (!r_valid || out_ready);
    assign w_data    = data[w_win*W +: W];
    // Explicit wrap so a non-power-of-two N never lets the pointer reach N.
    assign w_ptr_nxt = (w_win == IW'(N-1)) ? '0 : w_win + 1'b1;

    // One-hot grant to the winner, only in the cycle its data is captured.
    always_comb begin
        gnt = '0;
        if (w_cap) begin
            gnt[w_win] = 1'b1;
        end
    end

    // Output register and round-robin pointer; pointer only moves on round-robin captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_cap) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_idx   <= w_win;
                if (mode) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;

endmodule

// File: tb/tb_prio_arb_sel.sv
// Self-checking bench for prio_arb_sel: a 4x8 instance driven through a scoreboard
// and a 3x16 instance exercising the non-power-of-two pointer wrap.
module tb_prio_arb_sel;

    logic        clk;
    logic        rst_n, mode, out_ready;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;

    logic        rst_b_n, mode_b, out_ready_b;
    logic [2:0]  req_b;
    logic [47:0] data_b;
    logic [2:0]  gnt_b;
    logic        out_valid_b;
    logic [15:0] out_data_b;
    logic [1:0]  out_idx_b;

    int vecs = 0;
    int miss = 0;

    // scoreboard / reference model state
    logic [9:0] m_q[$];
    logic       m_valid;
    int         m_ptr;

    prio_arb_sel #(.N(4), .W(8), .IW(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .data(data), .gnt(gnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx)
    );

    prio_arb_sel #(.N(3), .W(16), .IW(2)) u_dut3 (
        .clk(clk), .rst_n(rst_b_n), .mode(mode_b), .req(req_b), .data(data_b), .gnt(gnt_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_idx(out_idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int arb(input int n, input logic [15:0] rq, input int p, input logic md);
        int start;
        start = md ? p : 0;
        for (int k = 0; k < n; k++) begin
            if (rq[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_q.delete();
    endtask

    // One cycle on the 4-channel instance: check gnt mid-cycle, push expectation,
    // then check the registered output just after the edge.
    task automatic step();
        int         w;
        logic       cap;
        logic [3:0] eg;
        logic [9:0] e;
        @(negedge clk);
        w   = arb(4, 16'(req), m_ptr, mode);
        cap = (w >= 0) && (!m_valid || out_ready);
        eg  = cap ? 4'(1 << w) : 4'b0000;
        chk("gnt", 32'(gnt), 32'(eg));
        if (cap) begin
            m_q.push_back({2'(w), data[w*8 +: 8]});
            if (mode) m_ptr = (w + 1) % 4;
        end
        @(posedge clk);
        #1;
        if (cap) begin
            m_valid = 1'b1;
            e = m_q.pop_front();
            chk("valid", 32'(out_valid), 32'd1);
            chk("idx", 32'(out_idx), 32'(e[9:8]));
            chk("data", 32'(out_data), 32'(e[7:0]));
        end else begin
            if (out_ready) m_valid = 1'b0;
            chk("valid", 32'(out_valid), 32'(m_valid));
        end
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq2[5];
        logic [2:0] g3[4];
        int i3[4];
        seq2 = '{0, 1, 2, 3, 0};
        g3   = '{3'b001, 3'b100, 3'b001, 3'b100};
        i3   = '{0, 2, 0, 2};

        rst_n = 1'b0; mode = 1'b0; req = '0; out_ready = 1'b0;
        data  = {8'h33, 8'h22, 8'h11, 8'hA0};
        rst_b_n = 1'b0; mode_b = 1'b0; req_b = '0; out_ready_b = 1'b0;
        data_b  = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        model_reset();

        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        rst_n = 1'b1;

        // 1: fixed priority picks lowest set index
        mode = 1'b0; req = 4'b1010; out_ready = 1'b1;
        step();
        chk("t1_data", 32'(out_data), 32'h11);
        chk("t1_idx", 32'(out_idx), 32'd1);
        req = 4'b0000;
        step();

        // 2: round-robin rotation from reset, no bubbles
        reset_a();
        mode = 1'b1; req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_seq", 32'(out_idx), 32'(seq2[i]));
            chk("t2_nobubble", 32'(out_valid), 32'd1);
        end

        // 3: stall holds output and suppresses grants
        req = 4'b0100; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_idx", 32'(out_idx), 32'd0);
            chk("t3_hold_data", 32'(out_data), 32'hA0);
        end
        out_ready = 1'b1;
        step();
        chk("t3_idx", 32'(out_idx), 32'd2);

        // 4: mode switch keeps the round-robin pointer (now 3)
        mode = 1'b0; req = 4'b1001;
        step();
        chk("t4_fixed", 32'(out_idx), 32'd0);
        mode = 1'b1;
        step();
        chk("t4_rr", 32'(out_idx), 32'd3);
        chk("t4_data", 32'(out_data), 32'h33);

        // 5: asynchronous reset mid-operation
        req = 4'b1000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        chk("t5_idx", 32'(out_idx), 32'd0);
        chk("t5_gnt", 32'(gnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("t5_first", 32'(out_idx), 32'd3);

        // 6: N=3 round-robin wrap
        @(posedge clk);
        #1;
        rst_b_n = 1'b1; mode_b = 1'b1; req_b = 3'b101; out_ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_gnt", 32'(gnt_b), 32'(g3[i]));
            @(posedge clk);
            #1;
            chk("t6_idx", 32'(out_idx_b), 32'(i3[i]));
            chk("t6_data", 32'(out_data_b), (i3[i] == 0) ? 32'hA0A0 : 32'hC2C2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
